// File: rtl/lc3_pkg.sv
// -----------------------------------------------------------------------------
// lc3_pkg
//   Shared definitions for the LC-3 control sequencer: state encodings (the
//   classic LC-3 state numbers plus INIT=47 and HALT=63), opcode constants and
//   the encodings of the sel_pc / sel_eab2 / alu_ctrl control fields.
//
//   Optional feature macro: LC3_SEQ_INDIRECT_EN (LDI/STI support). The state
//   names for the indirect states always exist. The sequencer only reaches
//   them, and treats them as memory states, when the macro is defined.
// -----------------------------------------------------------------------------
package lc3_pkg;

    typedef enum logic [5:0] {
        S_BR       = 6'd0,
        S_ADD      = 6'd1,
        S_LD       = 6'd2,
        S_ST       = 6'd3,
        S_JSR      = 6'd4,
        S_AND      = 6'd5,
        S_LDR      = 6'd6,
        S_STR      = 6'd7,
        S_NOT      = 6'd9,
        S_LDI      = 6'd10,
        S_STI      = 6'd11,
        S_JMP      = 6'd12,
        S_LEA      = 6'd14,
        S_WRITE    = 6'd16,
        S_FETCH    = 6'd18,
        S_JSR_R7   = 6'd20,
        S_JSR_PC   = 6'd21,
        S_BR_TAKEN = 6'd22,
        S_ST_DATA  = 6'd23,
        S_LDI_RD   = 6'd24,
        S_LD_RD    = 6'd25,
        S_LDI_PTR  = 6'd26,
        S_LD_WB    = 6'd27,
        S_STI_RD   = 6'd29,
        S_STI_PTR  = 6'd31,
        S_DECODE   = 6'd32,
        S_FETCH_RD = 6'd33,
        S_FETCH_IR = 6'd35,
        S_INIT     = 6'd47,
        S_HALT     = 6'd63
    } state_e;

    // Opcodes (ir[15:12])
    localparam logic [3:0] OP_BR  = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_LD  = 4'd2;
    localparam logic [3:0] OP_ST  = 4'd3;
    localparam logic [3:0] OP_JSR = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_LDR = 4'd6;
    localparam logic [3:0] OP_STR = 4'd7;
    localparam logic [3:0] OP_RTI = 4'd8;
    localparam logic [3:0] OP_NOT = 4'd9;
    localparam logic [3:0] OP_LDI = 4'd10;
    localparam logic [3:0] OP_STI = 4'd11;
    localparam logic [3:0] OP_JMP = 4'd12;
    localparam logic [3:0] OP_RES = 4'd13;
    localparam logic [3:0] OP_LEA = 4'd14;
    localparam logic [3:0] OP_TRAP = 4'd15;

    // PC input mux
    localparam logic [1:0] SEL_PC_INC  = 2'b00;
    localparam logic [1:0] SEL_PC_BUS  = 2'b01;
    localparam logic [1:0] SEL_PC_EAB  = 2'b10;
    localparam logic [1:0] SEL_PC_ZERO = 2'b11;

    // EAB second operand mux
    localparam logic [1:0] EAB2_ZERO  = 2'b00;
    localparam logic [1:0] EAB2_OFF6  = 2'b01;
    localparam logic [1:0] EAB2_OFF9  = 2'b10;
    localparam logic [1:0] EAB2_OFF11 = 2'b11;

    // EAB first operand mux
    localparam logic EAB1_PC  = 1'b0;
    localparam logic EAB1_SR1 = 1'b1;

    // ALU operation
    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOT  = 2'b11;

    // States that hold a memory access open until the memory reports ready.
    function automatic logic is_mem_state(input state_e s);
        logic r;
        r = (s == S_FETCH_RD) || (s == S_LD_RD) || (s == S_WRITE);
`ifdef LC3_SEQ_INDIRECT_EN
        r = r || (s == S_LDI_RD) || (s == S_STI_RD);
`endif
        return r;
    endfunction

endpackage

// File: rtl/lc3_seq_outputs.sv
// -----------------------------------------------------------------------------
// lc3_seq_outputs
//   Moore control-word decoder for the LC-3 sequencer. It maps the current
//   state (plus the IR register fields) to every datapath strobe. mem_ready
//   only gates ld_mdr, so that MDR captures read data in the cycle the memory
//   completes. Every output not named for a state is 0 in that state.
//
//   Parameters: REG_AW (register address width, IR fields zero-extended),
//               USE_MEM_READY (0: every memory access completes in one cycle).
//   Macro:      LC3_SEQ_INDIRECT_EN enables the LDI/STI state outputs.
//
//   Ports:
//     state, ir, mem_ready                        inputs
//     ena_pc/ena_marm/ena_alu/ena_mdr             bus drivers (at most one)
//     ld_pc/ld_ir/ld_mar/ld_mdr/ld_reg/ld_cc      register loads
//     sel_pc, sel_mar, sel_eab1, sel_eab2, sel_mdr, alu_ctrl  mux/op selects
//     sr1, sr2, dr                                register file addresses
//     mem_en, mem_we, halted                      memory request / status
// -----------------------------------------------------------------------------
module lc3_seq_outputs
    import lc3_pkg::*;
#(
    parameter int REG_AW        = 3,
    parameter int USE_MEM_READY = 1
) (
    input  state_e              state,
    input  logic [15:0]         ir,
    input  logic                mem_ready,
    output logic                ena_pc,
    output logic                ena_marm,
    output logic                ena_alu,
    output logic                ena_mdr,
    output logic                ld_pc,
    output logic                ld_ir,
    output logic                ld_mar,
    output logic                ld_mdr,
    output logic                ld_reg,
    output logic                ld_cc,
    output logic [1:0]          sel_pc,
    output logic                sel_mar,
    output logic                sel_eab1,
    output logic [1:0]          sel_eab2,
    output logic                sel_mdr,
    output logic [1:0]          alu_ctrl,
    output logic [REG_AW-1:0]   sr1,
    output logic [REG_AW-1:0]   sr2,
    output logic [REG_AW-1:0]   dr,
    output logic                mem_en,
    output logic                mem_we,
    output logic                halted
);

    logic mem_done;
    logic unused_ir_bits;

    assign mem_done       = (USE_MEM_READY == 0) || mem_ready;
    // Opcode and the imm5 bits are consumed elsewhere (top / datapath).
    assign unused_ir_bits = ^{ir[15:12], ir[5:3]};

    always_comb begin
        ena_pc   = 1'b0;
        ena_marm = 1'b0;
        ena_alu  = 1'b0;
        ena_mdr  = 1'b0;
        ld_pc    = 1'b0;
        ld_ir    = 1'b0;
        ld_mar   = 1'b0;
        ld_mdr   = 1'b0;
        ld_reg   = 1'b0;
        ld_cc    = 1'b0;
        sel_pc   = SEL_PC_INC;
        sel_mar  = 1'b0;
        sel_eab1 = EAB1_PC;
        sel_eab2 = EAB2_ZERO;
        sel_mdr  = 1'b0;
        alu_ctrl = ALU_PASS;
        sr1      = '0;
        sr2      = '0;
        dr       = '0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        halted   = 1'b0;

        case (state)
            S_INIT: begin
                ld_pc  = 1'b1;
                sel_pc = SEL_PC_ZERO;
            end
            S_FETCH: begin
                ena_pc = 1'b1;
                ld_mar = 1'b1;
                ld_pc  = 1'b1;
                sel_pc = SEL_PC_INC;
            end
            S_FETCH_RD, S_LD_RD: begin
                mem_en  = 1'b1;
                sel_mdr = 1'b1;
                ld_mdr  = mem_done;
            end
            S_FETCH_IR: begin
                ena_mdr = 1'b1;
                ld_ir   = 1'b1;
            end
            S_ADD, S_AND, S_NOT: begin
                dr      = REG_AW'(ir[11:9]);
                sr1     = REG_AW'(ir[8:6]);
                sr2     = REG_AW'(ir[2:0]);
                ena_alu = 1'b1;
                ld_reg  = 1'b1;
                ld_cc   = 1'b1;
                if (state == S_ADD) begin
                    alu_ctrl = ALU_ADD;
                end else if (state == S_AND) begin
                    alu_ctrl = ALU_AND;
                end else begin
                    alu_ctrl = ALU_NOT;
                end
            end
            S_BR_TAKEN: begin
                sel_eab1 = EAB1_PC;
                sel_eab2 = EAB2_OFF9;
                sel_pc   = SEL_PC_EAB;
                ld_pc    = 1'b1;
            end
            S_JMP: begin
                sr1      = REG_AW'(ir[8:6]);
                sel_eab1 = EAB1_SR1;
                sel_eab2 = EAB2_ZERO;
                sel_pc   = SEL_PC_EAB;
                ld_pc    = 1'b1;
            end
            S_JSR_R7: begin
                // Return address goes to R7 one cycle before PC changes.
                dr     = REG_AW'(3'd7);
                ena_pc = 1'b1;
                ld_reg = 1'b1;
            end
            S_JSR_PC: begin
                ld_pc  = 1'b1;
                sel_pc = SEL_PC_EAB;
                if (ir[11]) begin
                    sel_eab1 = EAB1_PC;
                    sel_eab2 = EAB2_OFF11;
                end else begin
                    sel_eab1 = EAB1_SR1;
                    sel_eab2 = EAB2_ZERO;
                    sr1      = REG_AW'(ir[8:6]);
                end
            end
            S_LEA: begin
                dr       = REG_AW'(ir[11:9]);
                sel_eab1 = EAB1_PC;
                sel_eab2 = EAB2_OFF9;
                ena_marm = 1'b1;
                ld_reg   = 1'b1;
            end
            S_LD, S_ST: begin
                ld_mar   = 1'b1;
                ena_marm = 1'b1;
                sel_eab1 = EAB1_PC;
                sel_eab2 = EAB2_OFF9;
            end
            S_LDR, S_STR: begin
                ld_mar   = 1'b1;
                ena_marm = 1'b1;
                sel_eab1 = EAB1_SR1;
                sel_eab2 = EAB2_OFF6;
                sr1      = REG_AW'(ir[8:6]);
            end
            S_LD_WB: begin
                dr      = REG_AW'(ir[11:9]);
                ena_mdr = 1'b1;
                ld_reg  = 1'b1;
                ld_cc   = 1'b1;
            end
            S_ST_DATA: begin
                // Source register passes through the ALU onto the bus into MDR.
                sr1      = REG_AW'(ir[11:9]);
                alu_ctrl = ALU_PASS;
                ena_alu  = 1'b1;
                ld_mdr   = 1'b1;
                sel_mdr  = 1'b0;
            end
            S_WRITE: begin
                mem_en = 1'b1;
                mem_we = 1'b1;
            end
`ifdef LC3_SEQ_INDIRECT_EN
            S_LDI, S_STI: begin
                ld_mar   = 1'b1;
                ena_marm = 1'b1;
                sel_eab1 = EAB1_PC;
                sel_eab2 = EAB2_OFF9;
            end
            S_LDI_RD, S_STI_RD: begin
                mem_en  = 1'b1;
                sel_mdr = 1'b1;
                ld_mdr  = mem_done;
            end
            S_LDI_PTR, S_STI_PTR: begin
                // The pointer just read becomes the effective address.
                ena_mdr = 1'b1;
                ld_mar  = 1'b1;
            end
`endif
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/lc3_sequencer.sv
// -----------------------------------------------------------------------------
// lc3_sequencer
//   LC-3 control unit: Moore FSM that walks fetch / decode / execute and drives
//   the datapath strobes. This file holds the state register and next-state
//   logic; the control word is decoded by lc3_seq_outputs.
//
//   Parameters: REG_AW, STATE_W, USE_MEM_READY, HALT_ON_ILLEGAL.
//   Macro:      LC3_SEQ_INDIRECT_EN adds LDI (10) and STI (11). Without it
//               those opcodes are illegal.
//
//   Memory handshake: a memory state (33, 25, 16, and 24/29 with the macro)
//   keeps mem_en high and stays put until mem_ready is seen high on a clock
//   edge. That edge completes the access, and ld_mdr is high only in that
//   cycle. With USE_MEM_READY=0, mem_ready is ignored and every access takes
//   one cycle.
//
//   Ports:
//     clk, reset_n (async, active-low), ir, n/z/p, mem_ready   inputs
//     ena_*, ld_*, sel_*, alu_ctrl, sr1/sr2/dr, mem_en/mem_we  control word
//     halted                                                   high in HALT
//     state                                                    debug state
// -----------------------------------------------------------------------------
module lc3_sequencer
    import lc3_pkg::*;
#(
    parameter int REG_AW          = 3,
    parameter int STATE_W         = 6,
    parameter int USE_MEM_READY   = 1,
    parameter int HALT_ON_ILLEGAL = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [15:0]         ir,
    input  logic                n,
    input  logic                z,
    input  logic                p,
    input  logic                mem_ready,
    output logic                ena_pc,
    output logic                ena_marm,
    output logic                ena_alu,
    output logic                ena_mdr,
    output logic                ld_pc,
    output logic                ld_ir,
    output logic                ld_mar,
    output logic                ld_mdr,
    output logic                ld_reg,
    output logic                ld_cc,
    output logic [1:0]          sel_pc,
    output logic                sel_mar,
    output logic                sel_eab1,
    output logic [1:0]          sel_eab2,
    output logic                sel_mdr,
    output logic [1:0]          alu_ctrl,
    output logic [REG_AW-1:0]   sr1,
    output logic [REG_AW-1:0]   sr2,
    output logic [REG_AW-1:0]   dr,
    output logic                mem_en,
    output logic                mem_we,
    output logic                halted,
    output logic [STATE_W-1:0]  state
);

    localparam state_e ILLEGAL_NEXT = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;

    state_e state_q;
    state_e state_d;
    logic   mem_done;
    logic   br_taken;

    assign mem_done = (USE_MEM_READY == 0) || mem_ready;
    assign br_taken = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
    assign state    = STATE_W'(state_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (is_mem_state(state_q) && !mem_done) begin
            state_d = state_q;
        end else begin
            case (state_q)
                S_INIT:     state_d = S_FETCH;
                S_FETCH:    state_d = S_FETCH_RD;
                S_FETCH_RD: state_d = S_FETCH_IR;
                S_FETCH_IR: state_d = S_DECODE;
                S_DECODE: begin
                    case (ir[15:12])
                        OP_BR:  state_d = S_BR;
                        OP_ADD: state_d = S_ADD;
                        OP_LD:  state_d = S_LD;
                        OP_ST:  state_d = S_ST;
                        OP_JSR: state_d = S_JSR;
                        OP_AND: state_d = S_AND;
                        OP_LDR: state_d = S_LDR;
                        OP_STR: state_d = S_STR;
                        OP_NOT: state_d = S_NOT;
`ifdef LC3_SEQ_INDIRECT_EN
                        OP_LDI: state_d = S_LDI;
                        OP_STI: state_d = S_STI;
`endif
                        OP_JMP: state_d = S_JMP;
                        OP_LEA: state_d = S_LEA;
                        // RTI, reserved, TRAP (and LDI/STI when absent)
                        default: state_d = ILLEGAL_NEXT;
                    endcase
                end
                S_ADD, S_AND, S_NOT, S_JMP, S_LEA: state_d = S_FETCH;
                S_BR:       state_d = br_taken ? S_BR_TAKEN : S_FETCH;
                S_BR_TAKEN: state_d = S_FETCH;
                S_JSR:      state_d = S_JSR_R7;
                S_JSR_R7:   state_d = S_JSR_PC;
                S_JSR_PC:   state_d = S_FETCH;
                S_LD, S_LDR: state_d = S_LD_RD;
                S_LD_RD:    state_d = S_LD_WB;
                S_LD_WB:    state_d = S_FETCH;
                S_ST, S_STR: state_d = S_ST_DATA;
                S_ST_DATA:  state_d = S_WRITE;
                S_WRITE:    state_d = S_FETCH;
`ifdef LC3_SEQ_INDIRECT_EN
                S_LDI:      state_d = S_LDI_RD;
                S_LDI_RD:   state_d = S_LDI_PTR;
                S_LDI_PTR:  state_d = S_LD_RD;
                S_STI:      state_d = S_STI_RD;
                S_STI_RD:   state_d = S_STI_PTR;
                S_STI_PTR:  state_d = S_ST_DATA;
`endif
                // Only reset leaves HALT.
                S_HALT:     state_d = S_HALT;
                default:    state_d = ILLEGAL_NEXT;
            endcase
        end
    end

    lc3_seq_outputs #(
        .REG_AW        (REG_AW),
        .USE_MEM_READY (USE_MEM_READY)
    ) u_outputs (
        .state     (state_q),
        .ir        (ir),
        .mem_ready (mem_ready),
        .ena_pc    (ena_pc),
        .ena_marm  (ena_marm),
        .ena_alu   (ena_alu),
        .ena_mdr   (ena_mdr),
        .ld_pc     (ld_pc),
        .ld_ir     (ld_ir),
        .ld_mar    (ld_mar),
        .ld_mdr    (ld_mdr),
        .ld_reg    (ld_reg),
        .ld_cc     (ld_cc),
        .sel_pc    (sel_pc),
        .sel_mar   (sel_mar),
        .sel_eab1  (sel_eab1),
        .sel_eab2  (sel_eab2),
        .sel_mdr   (sel_mdr),
        .alu_ctrl  (alu_ctrl),
        .sr1       (sr1),
        .sr2       (sr2),
        .dr        (dr),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .halted    (halted)
    );

endmodule

// File: tb/tb_lc3_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lc3_sequencer
//   Directed bench for lc3_sequencer. A table of per-cycle records (inputs,
//   expected state, expected control word) covers the main instruction flows.
//   Hand-written sequences cover memory stalls, HALT, async reset during a
//   memory wait and LDI. A second instance with USE_MEM_READY=0 checks
//   single-cycle memory timing.
// -----------------------------------------------------------------------------
module tb_lc3_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] ir = 16'h0000;
    logic        n = 1'b0, z = 1'b0, p = 1'b0;
    logic        mem_ready = 1'b1;

    logic       ena_pc, ena_marm, ena_alu, ena_mdr;
    logic       ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc;
    logic [1:0] sel_pc, sel_eab2, alu_ctrl;
    logic       sel_mar, sel_eab1, sel_mdr;
    logic [2:0] sr1, sr2, dr;
    logic       mem_en, mem_we, halted;
    logic [5:0] state;

    lc3_sequencer #(.REG_AW(3), .STATE_W(6), .USE_MEM_READY(1), .HALT_ON_ILLEGAL(1)) dut (
        .clk(clk), .reset_n(reset_n), .ir(ir), .n(n), .z(z), .p(p), .mem_ready(mem_ready),
        .ena_pc(ena_pc), .ena_marm(ena_marm), .ena_alu(ena_alu), .ena_mdr(ena_mdr),
        .ld_pc(ld_pc), .ld_ir(ld_ir), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_reg(ld_reg), .ld_cc(ld_cc),
        .sel_pc(sel_pc), .sel_mar(sel_mar), .sel_eab1(sel_eab1), .sel_eab2(sel_eab2), .sel_mdr(sel_mdr),
        .alu_ctrl(alu_ctrl), .sr1(sr1), .sr2(sr2), .dr(dr),
        .mem_en(mem_en), .mem_we(mem_we), .halted(halted), .state(state)
    );

    // Instance with mem_ready ignored (single-cycle memory)
    logic       nr_ena_pc, nr_ena_marm, nr_ena_alu, nr_ena_mdr;
    logic       nr_ld_pc, nr_ld_ir, nr_ld_mar, nr_ld_mdr, nr_ld_reg, nr_ld_cc;
    logic [1:0] nr_sel_pc, nr_sel_eab2, nr_alu_ctrl;
    logic       nr_sel_mar, nr_sel_eab1, nr_sel_mdr;
    logic [2:0] nr_sr1, nr_sr2, nr_dr;
    logic       nr_mem_en, nr_mem_we, nr_halted;
    logic [5:0] nr_state;

    lc3_sequencer #(.REG_AW(3), .STATE_W(6), .USE_MEM_READY(0), .HALT_ON_ILLEGAL(1)) dut_nr (
        .clk(clk), .reset_n(reset_n), .ir(ir), .n(n), .z(z), .p(p), .mem_ready(mem_ready),
        .ena_pc(nr_ena_pc), .ena_marm(nr_ena_marm), .ena_alu(nr_ena_alu), .ena_mdr(nr_ena_mdr),
        .ld_pc(nr_ld_pc), .ld_ir(nr_ld_ir), .ld_mar(nr_ld_mar), .ld_mdr(nr_ld_mdr),
        .ld_reg(nr_ld_reg), .ld_cc(nr_ld_cc),
        .sel_pc(nr_sel_pc), .sel_mar(nr_sel_mar), .sel_eab1(nr_sel_eab1), .sel_eab2(nr_sel_eab2),
        .sel_mdr(nr_sel_mdr), .alu_ctrl(nr_alu_ctrl), .sr1(nr_sr1), .sr2(nr_sr2), .dr(nr_dr),
        .mem_en(nr_mem_en), .mem_we(nr_mem_we), .halted(nr_halted), .state(nr_state)
    );

    // Control word as compared: {ena x4, ld x6, mem_en, mem_we, sel_pc, alu_ctrl, dr, sr1, sr2, eab1, eab2}
    logic [27:0] ctrl_act;
    assign ctrl_act = {ena_pc, ena_marm, ena_alu, ena_mdr,
                       ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc,
                       mem_en, mem_we, sel_pc, alu_ctrl, dr, sr1, sr2, sel_eab1, sel_eab2};

    localparam logic [27:0] INIT_CW = {4'b0000, 6'b100000, 2'b00, 2'b11, 2'b00,
                                       3'd0, 3'd0, 3'd0, 3'b000};

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] ir;
        logic [2:0]  nzp;
        logic [5:0]  st;
        logic [3:0]  en;
        logic [5:0]  ld;
        logic [1:0]  mem;
        logic [1:0]  spc;
        logic [1:0]  alu;
        logic [2:0]  dr;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic [2:0]  eab;
    } vec_t;

    vec_t exp_q[$];

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic [15:0] ir_v, input logic [2:0] nzp_v,
                                input logic [5:0] st_v, input logic [3:0] en_v,
                                input logic [5:0] ld_v, input logic [1:0] mem_v,
                                input logic [1:0] spc_v, input logic [1:0] alu_v,
                                input logic [2:0] dr_v, input logic [2:0] sr1_v,
                                input logic [2:0] sr2_v, input logic [2:0] eab_v);
        vec_t v;
        v.ir = ir_v; v.nzp = nzp_v; v.st = st_v; v.en = en_v; v.ld = ld_v; v.mem = mem_v;
        v.spc = spc_v; v.alu = alu_v; v.dr = dr_v; v.sr1 = sr1_v; v.sr2 = sr2_v; v.eab = eab_v;
        return v;
    endfunction

    // Fetch + decode: 18, 33 (ready at once), 35, 32
    task automatic add_fetch(input logic [15:0] ir_v, input logic [2:0] nzp_v);
        exp_q.push_back(mk(ir_v, nzp_v, 6'd18, 4'b1000, 6'b101000, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 3'b000));
        exp_q.push_back(mk(ir_v, nzp_v, 6'd33, 4'b0000, 6'b000100, 2'b10, 2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 3'b000));
        exp_q.push_back(mk(ir_v, nzp_v, 6'd35, 4'b0001, 6'b010000, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 3'b000));
        exp_q.push_back(mk(ir_v, nzp_v, 6'd32, 4'b0000, 6'b000000, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 3'b000));
    endtask

    // ---------------- driver / checker tasks ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input string nm, input logic [5:0] exp_st);
        settle();
        chk(nm, 32'(state), 32'(exp_st));
        tick();
    endtask

    // ---------------- test ----------------
    initial begin
        // Table: ADD, BRz taken / not taken, JSR, ST, LDR, NOT, JMP, LEA
        exp_q.push_back(mk(16'h1283, 3'b000, 6'd47, 4'b0000, 6'b100000, 2'b00, 2'b11, 2'b00, 3'd0, 3'd0, 3'd0, 3'b000));
        add_fetch(16'h1283, 3'b000);
        exp_q.push_back(mk(16'h1283, 3'b000, 6'd1,  4'b0010, 6'b000011, 2'b00, 2'b00, 2'b01, 3'd1, 3'd2, 3'd3, 3'b000));
        add_fetch(16'h0402, 3'b010);
        exp_q.push_back(mk(16'h0402, 3'b010, 6'd0,  4'b0000, 6'b000000, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 3'b000));
        exp_q.push_back(mk(16'h0402, 3'b010, 6'd22, 4'b0000, 6'b100000, 2'b00, 2'b10, 2'b00, 3'd0, 3'd0, 3'd0, 3'b010));
        add_fetch(16'h0402, 3'b100);
        exp_q.push_back(mk(16'h0402, 3'b100, 6'd0,  4'b0000, 6'b000000, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 3'b000));
        add_fetch(16'h4803, 3'b000);
        exp_q.push_back(mk(16'h4803, 3'b000, 6'd4,  4'b0000, 6'b000000, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 3'b000));
        exp_q.push_back(mk(16'h4803, 3'b000, 6'd20, 4'b1000, 6'b000010, 2'b00, 2'b00, 2'b00, 3'd7, 3'd0, 3'd0, 3'b000));
        exp_q.push_back(mk(16'h4803, 3'b000, 6'd21, 4'b0000, 6'b100000, 2'b00, 2'b10, 2'b00, 3'd0, 3'd0, 3'd0, 3'b011));
        add_fetch(16'h3A05, 3'b000);
        exp_q.push_back(mk(16'h3A05, 3'b000, 6'd3,  4'b0100, 6'b001000, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 3'b010));
        exp_q.push_back(mk(16'h3A05, 3'b000, 6'd23, 4'b0010, 6'b000100, 2'b00, 2'b00, 2'b00, 3'd0, 3'd5, 3'd0, 3'b000));
        exp_q.push_back(mk(16'h3A05, 3'b000, 6'd16, 4'b0000, 6'b000000, 2'b11, 2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 3'b000));
        add_fetch(16'h6A45, 3'b000);
        exp_q.push_back(mk(16'h6A45, 3'b000, 6'd6,  4'b0100, 6'b001000, 2'b00, 2'b00, 2'b00, 3'd0, 3'd1, 3'd0, 3'b101));
        exp_q.push_back(mk(16'h6A45, 3'b000, 6'd25, 4'b0000, 6'b000100, 2'b10, 2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 3'b000));
        exp_q.push_back(mk(16'h6A45, 3'b000, 6'd27, 4'b0001, 6'b000011, 2'b00, 2'b00, 2'b00, 3'd5, 3'd0, 3'd0, 3'b000));
        add_fetch(16'h967F, 3'b000);
        exp_q.push_back(mk(16'h967F, 3'b000, 6'd9,  4'b0010, 6'b000011, 2'b00, 2'b00, 2'b11, 3'd3, 3'd1, 3'd7, 3'b000));
        add_fetch(16'hC1C0, 3'b000);
        exp_q.push_back(mk(16'hC1C0, 3'b000, 6'd12, 4'b0000, 6'b100000, 2'b00, 2'b10, 2'b00, 3'd0, 3'd7, 3'd0, 3'b100));
        add_fetch(16'hE5FF, 3'b000);
        exp_q.push_back(mk(16'hE5FF, 3'b000, 6'd14, 4'b0100, 6'b000010, 2'b00, 2'b00, 2'b00, 3'd2, 3'd0, 3'd0, 3'b010));

        // Reset state
        repeat (2) @(negedge clk);
        settle();
        chk("reset_state", 32'(state), 32'd47);
        chk("reset_ctrl", 32'(ctrl_act), 32'(INIT_CW));
        chk("reset_misc", 32'({halted, sel_mdr, sel_mar}), 32'd0);
        reset_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < exp_q.size(); i++) begin
            ir = exp_q[i].ir;
            {n, z, p} = exp_q[i].nzp;
            mem_ready = 1'b1;
            settle();
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(exp_q[i].st));
            chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_act),
                32'({exp_q[i].en, exp_q[i].ld, exp_q[i].mem, exp_q[i].spc, exp_q[i].alu,
                     exp_q[i].dr, exp_q[i].sr1, exp_q[i].sr2, exp_q[i].eab}));
            tick();
        end

        // Fetch stalled 3 cycles in 33; no-ready instance leaves after one
        ir = 16'h1283; {n, z, p} = 3'b000; mem_ready = 1'b1;
        step("wait_pre", 6'd18);
        mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk($sformatf("wait%0d_state", c), 32'(state), 32'd33);
            chk($sformatf("wait%0d_mem", c), 32'({mem_en, sel_mdr, ld_mdr}), 32'b110);
            if (c == 0) begin
                chk("nr_state_33", 32'(nr_state), 32'd33);
                chk("nr_ld_mdr", 32'(nr_ld_mdr), 32'd1);
            end
            if (c == 1) chk("nr_state_35", 32'(nr_state), 32'd35);
            tick();
        end
        mem_ready = 1'b1;
        settle();
        chk("wait3_state", 32'(state), 32'd33);
        chk("wait3_ld_mdr", 32'({mem_en, sel_mdr, ld_mdr}), 32'b111);
        tick();
        step("wait_done", 6'd35);
        step("wait_dec", 6'd32);
        step("wait_add", 6'd1);

        // ST with write stretched by mem_ready low
        ir = 16'h3A05;
        step("st_18", 6'd18);
        step("st_33", 6'd33);
        step("st_35", 6'd35);
        step("st_32", 6'd32);
        step("st_3", 6'd3);
        settle();
        chk("st_23_sr1", 32'(sr1), 32'd5);
        chk("st_23_we", 32'(mem_we), 32'd0);
        tick();
        mem_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            settle();
            chk($sformatf("st_wait%0d_state", c), 32'(state), 32'd16);
            chk($sformatf("st_wait%0d_we", c), 32'({mem_en, mem_we}), 32'b11);
            tick();
        end
        mem_ready = 1'b1;
        step("st_16_last", 6'd16);
        settle();
        chk("st_back_18", 32'(state), 32'd18);
        chk("st_18_we", 32'(mem_we), 32'd0);

        // Opcode 13 halts until reset
        ir = 16'hD000;
        step("halt_18", 6'd18);
        step("halt_33", 6'd33);
        step("halt_35", 6'd35);
        step("halt_32", 6'd32);
        for (int c = 0; c < 3; c++) begin
            mem_ready = c[0];
            settle();
            chk($sformatf("halt%0d_state", c), 32'(state), 32'd63);
            chk($sformatf("halt%0d_halted", c), 32'(halted), 32'd1);
            chk($sformatf("halt%0d_ctrl", c), 32'(ctrl_act), 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        reset_n = 1'b0;
        settle();
        chk("halt_reset_state", 32'(state), 32'd47);
        chk("halt_reset_halted", 32'(halted), 32'd0);
        tick();
        reset_n = 1'b1;

        // Async reset while waiting in 25
        ir = 16'h2000;
        step("rst_47", 6'd47);
        step("rst_18", 6'd18);
        step("rst_33", 6'd33);
        step("rst_35", 6'd35);
        step("rst_32", 6'd32);
        step("rst_2", 6'd2);
        mem_ready = 1'b0;
        step("rst_25a", 6'd25);
        settle();
        chk("rst_25b", 32'(state), 32'd25);
        chk("rst_25b_mem", 32'({mem_en, ld_mdr}), 32'b10);
        reset_n = 1'b0;
        settle();
        chk("rst_async_state", 32'(state), 32'd47);
        chk("rst_async_ctrl", 32'(ctrl_act), 32'(INIT_CW));
        tick();
        reset_n = 1'b1;
        mem_ready = 1'b1;

        // LDI: illegal without the indirect feature
        ir = 16'hA000;
        step("ldi_47", 6'd47);
        step("ldi_18", 6'd18);
        step("ldi_33", 6'd33);
        step("ldi_35", 6'd35);
        step("ldi_32", 6'd32);
`ifdef LC3_SEQ_INDIRECT_EN
        settle();
        chk("ldi_10_ctrl", 32'({ena_marm, ld_mar, sel_eab2}), 32'b1110);
        chk("ldi_10_state", 32'(state), 32'd10);
        tick();
        step("ldi_24", 6'd24);
        settle();
        chk("ldi_26_ctrl", 32'({ena_mdr, ld_mar}), 32'b11);
        tick();
        step("ldi_25", 6'd25);
        step("ldi_27", 6'd27);
        step("ldi_18_end", 6'd18);
`else
        settle();
        chk("ldi_halt_state", 32'(state), 32'd63);
        chk("ldi_halted", 32'(halted), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
